// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and frame defaults.
// Also used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE     = 16;
  localparam int DEFAULT_DBIT   = 8;
  localparam int DEFAULT_SB_TCK = 16;

  // Mask that keeps only the low dbit bits of a byte.
  function automatic logic [7:0] data_mask(input int dbit);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < dbit) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DBIT data bits LSB-first, stop period, timed by a 16x tick.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DBIT   = DEFAULT_DBIT,
  parameter int SB_TCK = DEFAULT_SB_TCK
`ifdef UART_TX_PARITY_EN
  , parameter int PAR_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tck,
  input  logic [7:0] din,
  output logic       tx_busy,
  output logic       tx_done_tck,
  output logic       tx
);

  localparam logic [4:0] OS_LAST = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] SB_LAST = 5'(SB_TCK - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  uart_state_e r_state, w_state_nxt;
  logic [4:0]  r_s_cnt, w_s_cnt_nxt;
  logic [2:0]  r_n_cnt, w_n_cnt_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_BIT = 1'(PAR_ODD);
  logic r_par, w_par_nxt;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s_cnt <= 5'd0;
      r_n_cnt <= 3'd0;
      r_shreg <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Next-state, counter and shifter logic; the line level is derived from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shreg_nxt = r_shreg;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        // A tick coincident with acceptance is deliberately not counted.
        if (tx_start) begin
          w_shreg_nxt = din & data_mask(DBIT);
          w_s_cnt_nxt = 5'd0;
          w_state_nxt = ST_START;
          w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = (^(din & data_mask(DBIT))) ^ PAR_BIT;
`endif
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (s_tck) begin
          if (r_s_cnt == OS_LAST) begin
            w_s_cnt_nxt = 5'd0;
            w_n_cnt_nxt = 3'd0;
            w_state_nxt = ST_DATA;
          end else begin
            w_s_cnt_nxt = r_s_cnt + 5'd1;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt;
        end
      end
      ST_DATA: begin
        if (s_tck) begin
          if (r_s_cnt == OS_LAST) begin
            w_s_cnt_nxt = 5'd0;
            w_shreg_nxt = r_shreg >> 1;
            if (r_n_cnt == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              w_state_nxt = ST_PARITY;
`else
              w_state_nxt = ST_STOP;
`endif
            end else begin
              w_n_cnt_nxt = r_n_cnt + 3'd1;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 5'd1;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tck) begin
          if (r_s_cnt == OS_LAST) begin
            w_s_cnt_nxt = 5'd0;
            w_state_nxt = ST_STOP;
          end else begin
            w_s_cnt_nxt = r_s_cnt + 5'd1;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt;
        end
      end
`endif
      ST_STOP: begin
        if (s_tck) begin
          if (r_s_cnt == SB_LAST) begin
            w_s_cnt_nxt = 5'd0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_s_cnt_nxt = r_s_cnt + 5'd1;
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_s_cnt_nxt = 5'd0;
        w_n_cnt_nxt = 3'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  assign tx          = r_tx;
  assign tx_busy     = r_busy;
  assign tx_done_tck = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: table of frames plus hand-written corner sequences.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
  localparam int FRAME_C   = 176;
  localparam int T2_LOW    = 640;
`else
  localparam bit PARITY_ON = 1'b0;
  localparam int FRAME_C   = 160;
  localparam int T2_LOW    = 576;
`endif
  localparam int T2_DONE = T2_LOW + 128;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic       tx_start2;
  logic       s_tck;
  logic [7:0] din;
  logic       tx, tx_busy, tx_done_tck;
  logic       tx2, busy2, done2;

  int n_chk = 0;
  int n_err = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
    logic       par;
    int         poke_c;
  } vec_t;

  vec_t vecs[7];

  uart_tx_serializer dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tck(s_tck), .din(din),
    .tx_busy(tx_busy), .tx_done_tck(tx_done_tck), .tx(tx)
  );

  uart_tx_serializer #(.SB_TCK(32)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start2), .s_tck(s_tck), .din(din),
    .tx_busy(busy2), .tx_done_tck(done2), .tx(tx2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_div == 0) begin
        s_tck = 1'b0;
      end else begin
        s_tck = (tick_cnt == 0);
        tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // line = {stop, data[7:0], start}; bit 9 of a frame is parity when enabled.
  function automatic logic exp_bit(input logic [9:0] line, input logic par, input int b);
    if (b < 9) return line[b];
    if (PARITY_ON && b == 9) return par;
    return line[9];
  endfunction

  task automatic start_frame(input logic [7:0] d, input bit use2);
    int guard;
    guard = 0;
    @(posedge clk);
    #2;
    while (tick_div != 0 && !s_tck && guard < 64) begin
      @(posedge clk);
      #2;
      guard++;
    end
    din = d;
    if (use2) tx_start2 = 1'b1;
    else      tx_start  = 1'b1;
    @(posedge clk);
    #1;
    tx_start  = 1'b0;
    tx_start2 = 1'b0;
  endtask

  // Called right after the acceptance edge; cycle c counts clocks after that edge.
  task automatic check_frame(input logic [9:0] line, input logic par, input string tag,
                             input int poke_c);
    int n_done, done_c;
    logic busy_pre;
    n_done = 0;
    done_c = -1;
    busy_pre = 1'b0;
    for (int c = 0; c < FRAME_C + 4; c++) begin
      @(negedge clk);
      if (c % 16 == 8 && c < FRAME_C)
        chk($sformatf("%s bit%0d", tag, c / 16), tx, exp_bit(line, par, c / 16));
      if (tx_done_tck) begin
        n_done++;
        done_c = c;
        chk({tag, " busy_at_done"}, tx_busy, 0);
      end
      if (c == FRAME_C - 1) busy_pre = tx_busy;
      if (c == poke_c) begin
        din = 8'hFF;
        tx_start = 1'b1;
      end else if (c == poke_c + 1) begin
        tx_start = 1'b0;
      end
    end
    chk({tag, " n_done"}, n_done, 1);
    chk({tag, " done_cycle"}, done_c, FRAME_C);
    chk({tag, " busy_before_done"}, busy_pre, 1);
    chk({tag, " idle_after"}, tx_busy, 0);
  endtask

  initial begin
    int nd, d1, d2, nl, nh, nb, first_hi, late_lo;

    vecs[0] = '{8'hA5, 10'h34A, 1'b0, -1};
    vecs[1] = '{8'h00, 10'h200, 1'b0, -1};
    vecs[2] = '{8'hFF, 10'h3FE, 1'b0, -1};
    vecs[3] = '{8'h5A, 10'h2B4, 1'b0, 66};
    vecs[4] = '{8'h80, 10'h300, 1'b1, -1};
    vecs[5] = '{8'h01, 10'h202, 1'b1, -1};
    vecs[6] = '{8'h07, 10'h20E, 1'b1, -1};

    // Reset held together with tx_start: reset must win.
    reset = 1'b1;
    tx_start = 1'b1;
    tx_start2 = 1'b1;
    din = 8'hA5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", tx_busy, 0);
    chk("reset done", tx_done_tck, 0);
    chk("reset tx2", tx2, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tx_start = 1'b0;
    tx_start2 = 1'b0;
    @(negedge clk);
    chk("reset_wins busy", tx_busy, 0);
    chk("reset_wins tx", tx, 1);

    for (int i = 0; i < 7; i++) begin
      start_frame(vecs[i].din, 1'b0);
      check_frame(vecs[i].line, vecs[i].par, $sformatf("vec%0d_%02h", i, vecs[i].din),
                  vecs[i].poke_c);
    end

    // Back-to-back frames with tx_start held high; FIFO presents the next byte after the pop.
    @(posedge clk);
    #2;
    din = 8'h31;
    tx_start = 1'b1;
    @(posedge clk);
    nd = 0; d1 = -1; d2 = -1;
    for (int c = 0; c < 2 * FRAME_C + 6; c++) begin
      @(negedge clk);
      if (c < FRAME_C && c % 16 == 8)
        chk($sformatf("b2b f1 bit%0d", c / 16), tx, exp_bit(10'h262, 1'b1, c / 16));
      if (c > FRAME_C && c < 2 * FRAME_C + 1 && (c - FRAME_C - 1) % 16 == 8)
        chk($sformatf("b2b f2 bit%0d", (c - FRAME_C - 1) / 16), tx,
            exp_bit(10'h264, 1'b1, (c - FRAME_C - 1) / 16));
      if (c == FRAME_C) chk("b2b gap high", tx, 1);
      if (c == FRAME_C + 1) chk("b2b next start", tx, 0);
      if (tx_done_tck) begin
        nd++;
        if (nd == 1) begin
          d1 = c;
          din = 8'h32;
        end else begin
          d2 = c;
          tx_start = 1'b0;
        end
      end
    end
    chk("b2b n_done", nd, 2);
    chk("b2b done1", d1, FRAME_C);
    chk("b2b done2", d2, 2 * FRAME_C + 1);
    chk("b2b idle", tx_busy, 0);

    // Reset for one clock during data bit 5 abandons the frame.
    start_frame(8'hA5, 1'b0);
    repeat (101) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst tx", tx, 1);
    chk("midrst busy", tx_busy, 0);
    chk("midrst done", tx_done_tck, 0);
    nd = 0; nl = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_done_tck) nd++;
      if (!tx) nl++;
    end
    chk("midrst no_done", nd, 0);
    chk("midrst line_idle", nl, 0);
    start_frame(8'hC3, 1'b0);
    check_frame(10'h386, 1'b0, "after_rst", -1);

    // No ticks: frame freezes in START.
    tick_div = 0;
    start_frame(8'hA5, 1'b0);
    nh = 0; nb = 0; nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx) nh++;
      if (!tx_busy) nb++;
      if (tx_done_tck) nd++;
    end
    chk("notick tx_low", nh, 0);
    chk("notick busy", nb, 0);
    chk("notick no_done", nd, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick_div = 4;

    // Tick every 4 clocks, two stop bits, all-zero data on the second instance.
    start_frame(8'h00, 1'b1);
    first_hi = -1; late_lo = 0; nd = 0; d1 = -1;
    for (int c = 0; c < T2_DONE + 8; c++) begin
      @(negedge clk);
      if (first_hi < 0 && tx2) first_hi = c;
      else if (first_hi >= 0 && !tx2) late_lo++;
      if (done2) begin
        nd++;
        d1 = c;
        chk("t2 busy_at_done", busy2, 0);
      end
    end
    chk("t2 low_len", first_hi, T2_LOW);
    chk("t2 done_cycle", d1, T2_DONE);
    chk("t2 n_done", nd, 1);
    chk("t2 no_low_after", late_lo, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
